// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, bubble encoding and
// the IF/ID payload type.
package fetch_controller_pkg;

  localparam logic [1:0] FETCH_ST_BOOT = 2'd0;
  localparam logic [1:0] FETCH_ST_RUN  = 2'd1;
  localparam logic [1:0] FETCH_ST_HALT = 2'd2;

  // Also used by the decode stage to recognise a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  // Full 32-bit unsigned compare; a wrapped PC is out of range.
  function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] limit);
    return pc < limit;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction memory port and the
// IF/ID outputs toward decode.
interface fetch_controller_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  // Fetch controller side.
  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
  );

  // Hazard unit / memory / decode side.
  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
  );

endinterface

// File: rtl/fetch_controller_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, load captures the fetched
// word, otherwise the contents hold.
module fetch_controller_if_id_reg
  import fetch_controller_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q, q_d;

  // Flush has priority over load; neither means hold.
  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d = IF_ID_BUBBLE;
    end else if (load) begin
      q_d = d;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= IF_ID_BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC and the BOOT/RUN/HALT sequencing, drives the
// instruction memory address and feeds the IF/ID register.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_controller_if.master bus
);

  localparam logic [31:0] PcLimit = 32'(IMEM_WORDS * 4);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        ifid_load, ifid_flush;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  if_id_t      ifid_d, ifid_q;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  assign ifid_d = '{instr: bus.imem_instr, pc4: pc_plus4, valid: 1'b1};

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      FETCH_ST_BOOT: begin
        state_d    = FETCH_ST_RUN;
        ifid_flush = 1'b1;
      end
      FETCH_ST_RUN: begin
        if (bus.redirect) begin
          // Drop the wrong-path fetch; redirect wins over stall.
          pc_d       = redirect_tgt;
          ifid_flush = 1'b1;
        end else if (bus.stall) begin
          // Hold everything.
        end else if (!pc_in_range(pc_q, PcLimit)) begin
          state_d    = FETCH_ST_HALT;
          halted_d   = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      FETCH_ST_HALT: begin
        ifid_flush = 1'b1;
        if (bus.redirect && pc_in_range(redirect_tgt, PcLimit)) begin
          state_d  = FETCH_ST_RUN;
          pc_d     = redirect_tgt;
          halted_d = 1'b0;
        end
      end
      default: begin
        // Unused encoding: restart cleanly.
        state_d    = FETCH_ST_BOOT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  // PC, FSM state and halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_ST_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_controller_if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.halted      = halted_q;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_pc4   = ifid_q.pc4;
  assign bus.if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: three instances cover the normal
// 128-word store, a 4-word store (end of program) and a wrapping reset PC.
module tb_fetch_controller;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic [31:0] mem [0:127];
  int compared;
  int mismatched;

  fetch_controller_if bus_a ();
  fetch_controller_if bus_b ();
  fetch_controller_if bus_c ();

  fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(128)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(128)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_c),
    .bus   (bus_c)
  );

  // Combinational instruction memory, one per instance, same program image.
  assign bus_a.imem_instr = (bus_a.imem_addr[31:9] == 23'd0) ? mem[bus_a.imem_addr[8:2]] : 32'h0;
  assign bus_b.imem_instr = (bus_b.imem_addr[31:9] == 23'd0) ? mem[bus_b.imem_addr[8:2]] : 32'h0;
  assign bus_c.imem_instr = (bus_c.imem_addr[31:9] == 23'd0) ? mem[bus_c.imem_addr[8:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h2008_0001 + 32'(i);

    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_pc = 32'h0;
    bus_b.stall = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_pc = 32'h0;
    bus_c.stall = 1'b0; bus_c.redirect = 1'b0; bus_c.redirect_pc = 32'h0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) tick();

    // 1 reset values and boot sequence
    check("rst_pc",     bus_a.imem_addr, 32'h0);
    check("rst_valid",  bus_a.if_id_valid, 1'b0);
    check("rst_instr",  bus_a.if_id_instr, 32'h0);
    check("rst_pc4",    bus_a.if_id_pc4, 32'h0);
    check("rst_halted", bus_a.halted, 1'b0);
    check("rst_pc_c",   bus_c.imem_addr, 32'hFFFF_FFFC);
    rst_a = 1'b1;
    tick();
    check("boot_valid", bus_a.if_id_valid, 1'b0);
    check("boot_pc",    bus_a.imem_addr, 32'h0);
    tick();
    check("w0_instr", bus_a.if_id_instr, mem[0]);
    check("w0_pc4",   bus_a.if_id_pc4, 32'h4);
    check("w0_valid", bus_a.if_id_valid, 1'b1);
    tick();
    check("w1_instr", bus_a.if_id_instr, mem[1]);
    check("w1_pc4",   bus_a.if_id_pc4, 32'h8);
    check("w1_pc",    bus_a.imem_addr, 32'h8);

    // 2 stall for two cycles at pc=0x8
    bus_a.stall = 1'b1;
    tick();
    check("st1_pc",    bus_a.imem_addr, 32'h8);
    check("st1_instr", bus_a.if_id_instr, mem[1]);
    check("st1_pc4",   bus_a.if_id_pc4, 32'h8);
    tick();
    check("st2_pc",    bus_a.imem_addr, 32'h8);
    check("st2_instr", bus_a.if_id_instr, mem[1]);
    check("st2_valid", bus_a.if_id_valid, 1'b1);
    bus_a.stall = 1'b0;
    tick();
    check("st_rel_instr", bus_a.if_id_instr, mem[2]);
    check("st_rel_pc4",   bus_a.if_id_pc4, 32'hC);
    check("st_rel_pc",    bus_a.imem_addr, 32'hC);

    // 3 redirect together with stall; low address bits dropped
    bus_a.stall = 1'b1; bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h23;
    tick();
    check("rd_pc",    bus_a.imem_addr, 32'h20);
    check("rd_valid", bus_a.if_id_valid, 1'b0);
    check("rd_instr", bus_a.if_id_instr, 32'h0);
    check("rd_pc4",   bus_a.if_id_pc4, 32'h0);
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0;
    tick();
    check("rd_tgt_instr", bus_a.if_id_instr, mem[8]);
    check("rd_tgt_pc4",   bus_a.if_id_pc4, 32'h24);
    check("rd_tgt_valid", bus_a.if_id_valid, 1'b1);

    // 5 async reset between edges at pc=0x18, with a redirect pending
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h14;
    tick();
    check("rd2_pc", bus_a.imem_addr, 32'h14);
    bus_a.redirect = 1'b0;
    tick();
    check("pre_ar_pc",    bus_a.imem_addr, 32'h18);
    check("pre_ar_instr", bus_a.if_id_instr, mem[5]);
    check("pre_ar_valid", bus_a.if_id_valid, 1'b1);
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 32'h40;
    #2;
    rst_a = 1'b0;
    #1;
    check("ar_pc",    bus_a.imem_addr, 32'h0);
    check("ar_valid", bus_a.if_id_valid, 1'b0);
    check("ar_instr", bus_a.if_id_instr, 32'h0);
    check("ar_pc4",   bus_a.if_id_pc4, 32'h0);
    bus_a.redirect = 1'b0;
    tick();
    tick();
    check("ar_hold_pc", bus_a.imem_addr, 32'h0);
    rst_a = 1'b1;
    tick();
    check("reboot_valid", bus_a.if_id_valid, 1'b0);
    check("reboot_pc",    bus_a.imem_addr, 32'h0);
    tick();
    check("reboot_instr", bus_a.if_id_instr, mem[0]);
    check("reboot_pc4",   bus_a.if_id_pc4, 32'h4);

    // 4 end of program with a 4-word store
    rst_b = 1'b1;
    tick();
    check("b_boot_valid", bus_b.if_id_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b_run_instr", bus_b.if_id_instr, mem[k]);
      check("b_run_pc4",   bus_b.if_id_pc4, 32'(4 * (k + 1)));
    end
    check("b_run_halted", bus_b.halted, 1'b0);
    tick();
    check("b_halt",       bus_b.halted, 1'b1);
    check("b_halt_valid", bus_b.if_id_valid, 1'b0);
    check("b_halt_pc",    bus_b.imem_addr, 32'h10);
    bus_b.stall = 1'b1;
    tick();
    check("b_halt_st",    bus_b.halted, 1'b1);
    check("b_halt_st_pc", bus_b.imem_addr, 32'h10);
    bus_b.stall = 1'b0; bus_b.redirect = 1'b1; bus_b.redirect_pc = 32'h40;
    tick();
    check("b_oor_halted", bus_b.halted, 1'b1);
    check("b_oor_pc",     bus_b.imem_addr, 32'h10);
    bus_b.redirect_pc = 32'h4;
    tick();
    check("b_resume_halted", bus_b.halted, 1'b0);
    check("b_resume_pc",     bus_b.imem_addr, 32'h4);
    check("b_resume_valid",  bus_b.if_id_valid, 1'b0);
    bus_b.redirect = 1'b0;
    tick();
    check("b_resume_instr", bus_b.if_id_instr, mem[1]);
    check("b_resume_pc4",   bus_b.if_id_pc4, 32'h8);
    check("b_resume_v",     bus_b.if_id_valid, 1'b1);

    // 6 reset PC at the top of the address space
    rst_c = 1'b1;
    tick();
    check("c_boot_pc",     bus_c.imem_addr, 32'hFFFF_FFFC);
    check("c_boot_halted", bus_c.halted, 1'b0);
    tick();
    check("c_halt",       bus_c.halted, 1'b1);
    check("c_halt_pc",    bus_c.imem_addr, 32'hFFFF_FFFC);
    check("c_halt_valid", bus_c.if_id_valid, 1'b0);
    tick();
    check("c_hold",    bus_c.halted, 1'b1);
    check("c_hold_pc", bus_c.imem_addr, 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
